encoder_layer_2_attention_self_value_weight_sink: RTL and testbench

//  Write-side counterpart of the value-weight source: receives value-weight elements as a

---
 rtl/encoder_layer_2_attention_self_value_weight_sink.sv | 126 ++++++++++++
 tb/tb_encoder_layer_2_attention_self_value_weight_sink.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_layer_2_attention_self_value_weight_sink.sv
// Run-time loader for the value-weight RAM: packs streamed beats into rows and
// exposes the same 2-cycle addr/ce/q read port as the weight ROM it replaces.
module encoder_layer_2_attention_self_value_weight_sink #(
  parameter int PRECISION_0       = 16,
  parameter int TENSOR_SIZE_DIM_0 = 32,
  parameter int PARALLELISM_DIM_0 = 4,
  parameter int DEPTH             = 576,
  parameter int ADDR_WIDTH        = $clog2(DEPTH) + 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [PRECISION_0-1:0]                 data_in [PARALLELISM_DIM_0],
  input  logic                                   data_in_valid,
  output logic                                   data_in_ready,
  input  logic                                   restart,
  output logic                                   load_done,
  output logic [ADDR_WIDTH-1:0]                  rows_loaded,
  input  logic [ADDR_WIDTH-1:0]                  rd_addr,
  input  logic                                   rd_ce,
  output logic [PRECISION_0*TENSOR_SIZE_DIM_0-1:0] rd_q
);

  localparam int BEATS     = TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0;
  localparam int BEAT_BITS = PRECISION_0 * PARALLELISM_DIM_0;
  localparam int ROW_W     = PRECISION_0 * TENSOR_SIZE_DIM_0;
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(DEPTH);

  typedef enum logic {LOAD, DONE} state_e;

  state_e                  state_q;
  logic [BEAT_W-1:0]       beat_cnt_q;
  logic [ADDR_WIDTH-1:0]   row_cnt_q;
  logic                    load_done_q;

  logic [BEAT_BITS-1:0]    beat_flat;
  logic [BEAT_BITS-1:0]    buf_q [BEATS];
  logic [ROW_W-1:0]        row_d;
  logic                    accept;
  logic                    row_wr;

  logic [ROW_W-1:0]        mem_q [DEPTH];
  logic [ROW_W-1:0]        rd_p0_q;
  logic [ROW_W-1:0]        rd_p1_q;

  always_comb begin
    beat_flat = '0;
    for (int j = 0; j < PARALLELISM_DIM_0; j++) begin
      beat_flat[j*PRECISION_0 +: PRECISION_0] = data_in[j];
    end
  end

  assign data_in_ready = (state_q == LOAD) && !restart;
  assign accept        = data_in_valid && data_in_ready;
  assign row_wr        = accept && (beat_cnt_q == LAST_BEAT);

  // The closing beat bypasses the buffer so the row lands in RAM on the accepting edge.
  always_comb begin
    row_d = '0;
    for (int b = 0; b < BEATS; b++) begin
      row_d[b*BEAT_BITS +: BEAT_BITS] = (beat_cnt_q == BEAT_W'(b)) ? beat_flat : buf_q[b];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= LOAD;
      beat_cnt_q  <= '0;
      row_cnt_q   <= '0;
      load_done_q <= 1'b0;
    end else if (restart) begin
      state_q     <= LOAD;
      beat_cnt_q  <= '0;
      row_cnt_q   <= '0;
      load_done_q <= 1'b0;
    end else if (accept) begin
      if (beat_cnt_q == LAST_BEAT) begin
        beat_cnt_q <= '0;
        row_cnt_q  <= row_cnt_q + 1'b1;
        if (row_cnt_q == LAST_ROW) begin
          state_q     <= DONE;
          load_done_q <= 1'b1;
        end
      end else begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      buf_q[beat_cnt_q] <= beat_flat;
    end
  end

  always_ff @(posedge clk) begin
    if (row_wr) begin
      mem_q[row_cnt_q[IDX_W-1:0]] <= row_d;
    end
  end

  // Read stage p0: RAM output register; out-of-range rows read as zero.
  always_ff @(posedge clk) begin
    if (rd_ce) begin
      rd_p0_q <= (rd_addr < DEPTH_A) ? mem_q[rd_addr[IDX_W-1:0]] : '0;
    end
  end

  // Read stage p1: output register, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_p1_q <= '0;
    end else if (rd_ce) begin
      rd_p1_q <= rd_p0_q;
    end
  end

  assign rd_q        = rd_p1_q;
  assign load_done   = load_done_q;
  assign rows_loaded = row_cnt_q;

endmodule

// File: tb/tb_encoder_layer_2_attention_self_value_weight_sink.sv
// Bench for the value-weight sink: a queue-based packing model tracks accepted
// elements and the rows they form; reads are compared against it and against closed-form rows.
module tb_encoder_layer_2_attention_self_value_weight_sink;

  localparam int P     = 16;
  localparam int T     = 32;
  localparam int PAR   = 4;
  localparam int DEPTH = 576;
  localparam int AW    = $clog2(DEPTH) + 1;
  localparam int ROW_W = P * T;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [P-1:0]     din [PAR];
  logic             din_valid;
  logic             din_ready;
  logic             restart_r;
  logic             load_done;
  logic [AW-1:0]    rows_loaded;
  logic [AW-1:0]    rd_addr;
  logic             rd_ce;
  logic [ROW_W-1:0] rd_q;

  encoder_layer_2_attention_self_value_weight_sink dut (
    .clk           (clk),
    .rst           (rst_n),
    .data_in       (din),
    .data_in_valid (din_valid),
    .data_in_ready (din_ready),
    .restart       (restart_r),
    .load_done     (load_done),
    .rows_loaded   (rows_loaded),
    .rd_addr       (rd_addr),
    .rd_ce         (rd_ce),
    .rd_q          (rd_q)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [ROW_W-1:0] mm [DEPTH];
  logic [P-1:0]     pend [$];
  int               mrow;
  bit               mdone;
  bit               last_acc;
  int               sidx;

  int checks;
  int errors;

  typedef struct {
    logic [AW-1:0] addr;
    logic [P-1:0]  e0;
    logic [P-1:0]  e31;
    bit            chk;
  } rd_vec_t;

  rd_vec_t tbl [7];

  task automatic chk(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] frow(input int r, input logic [P-1:0] offs);
    logic [ROW_W-1:0] row;
    for (int e = 0; e < T; e++) row[e*P +: P] = 16'(r * T + e) + offs;
    return row;
  endfunction

  task automatic model_reset();
    pend.delete();
    mrow  = 0;
    mdone = 1'b0;
  endtask

  task automatic drive_beat(input bit v, input logic [P-1:0] offs);
    din_valid = v;
    for (int j = 0; j < PAR; j++) din[j] = 16'(sidx + j) + offs;
  endtask

  // One clock: update the model at the edge, check status outputs on the falling edge.
  task automatic tick();
    bit acc;
    logic [ROW_W-1:0] row;
    @(posedge clk);
    acc = din_valid && rst_n && !mdone && !restart_r;
    if (!rst_n || restart_r) begin
      model_reset();
    end else if (acc) begin
      for (int j = 0; j < PAR; j++) pend.push_back(din[j]);
      if (pend.size() == T) begin
        for (int e = 0; e < T; e++) row[e*P +: P] = pend[e];
        mm[mrow] = row;
        mrow++;
        pend.delete();
        if (mrow == DEPTH) mdone = 1'b1;
      end
    end
    last_acc = acc;
    @(negedge clk);
    chk("rows_loaded", ROW_W'(rows_loaded), ROW_W'(mrow));
    chk("load_done", ROW_W'(load_done), ROW_W'(mdone));
    chk("data_in_ready", ROW_W'(din_ready), ROW_W'(!mdone && !restart_r));
  endtask

  task automatic read1(input logic [AW-1:0] a);
    rd_addr = a;
    rd_ce   = 1'b1;
    tick();
    tick();
    rd_ce   = 1'b0;
  endtask

  task automatic read_all_formula(input logic [P-1:0] offs);
    for (int k = 0; k <= DEPTH; k++) begin
      rd_addr = (k < DEPTH) ? AW'(k) : '0;
      rd_ce   = 1'b1;
      tick();
      if (k >= 1) chk($sformatf("row%0d", k - 1), rd_q, frow(k - 1, offs));
    end
    rd_ce = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int cyc;
    int nrest;
    bit v;
    bit rs;
    logic [ROW_W-1:0] old5;
    logic [ROW_W-1:0] new5;

    tbl[0] = '{addr: 11'd0,    e0: 16'd0,     e31: 16'd31,    chk: 1'b1};
    tbl[1] = '{addr: 11'd1,    e0: 16'd32,    e31: 16'd63,    chk: 1'b1};
    tbl[2] = '{addr: 11'd5,    e0: 16'd160,   e31: 16'd191,   chk: 1'b1};
    tbl[3] = '{addr: 11'd600,  e0: 16'd0,     e31: 16'd0,     chk: 1'b0};
    tbl[4] = '{addr: 11'd287,  e0: 16'd9184,  e31: 16'd9215,  chk: 1'b1};
    tbl[5] = '{addr: 11'd2047, e0: 16'd0,     e31: 16'd0,     chk: 1'b0};
    tbl[6] = '{addr: 11'd575,  e0: 16'd18400, e31: 16'd18431, chk: 1'b1};

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    din_valid = 1'b0;
    restart_r = 1'b0;
    rd_ce     = 1'b0;
    rd_addr   = '0;
    sidx      = 0;
    last_acc  = 1'b0;
    for (int j = 0; j < PAR; j++) din[j] = '0;
    model_reset();

    repeat (3) tick();
    chk("reset_rd_q", rd_q, '0);
    rst_n = 1'b1;
    tick();

    // asynchronous reset in the middle of a load
    sidx = 0;
    repeat (12) begin
      drive_beat(1'b1, 16'h0);
      tick();
      if (last_acc) sidx += PAR;
    end
    din_valid = 1'b0;
    read1('0);
    chk("pre_reset_row0", rd_q, frow(0, 16'h0));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rows_loaded", ROW_W'(rows_loaded), '0);
    chk("async_load_done", ROW_W'(load_done), '0);
    chk("async_rd_q", rd_q, '0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_ready", ROW_W'(din_ready), ROW_W'(1));

    // full-rate load of every row
    sidx = 0;
    cyc  = 0;
    while (!mdone && cyc < 10000) begin
      drive_beat(1'b1, 16'h0);
      tick();
      if (last_acc) sidx += PAR;
      cyc++;
    end
    din_valid = 1'b0;
    chk("full_load_done", ROW_W'(load_done), ROW_W'(1));
    chk("full_load_elems", ROW_W'(sidx), ROW_W'(DEPTH * T));
    chk("full_load_cycles", ROW_W'(cyc), ROW_W'(DEPTH * T / PAR));
    read_all_formula(16'h0);

    for (int i = 0; i < 7; i++) begin
      read1(tbl[i].addr);
      if (tbl[i].chk) begin
        chk($sformatf("tbl%0d_e0", i), ROW_W'(rd_q[P-1:0]), ROW_W'(tbl[i].e0));
        chk($sformatf("tbl%0d_e31", i), ROW_W'(rd_q[31*P +: P]), ROW_W'(tbl[i].e31));
      end
    end

    // DONE ignores incoming beats
    repeat (10) begin
      din_valid = 1'b1;
      for (int j = 0; j < PAR; j++) din[j] = 16'hDEAD;
      tick();
    end
    din_valid = 1'b0;
    read1(11'd0);
    chk("done_row0", rd_q, frow(0, 16'h0));
    read1(11'd300);
    chk("done_row300", rd_q, frow(300, 16'h0));
    read1(11'd575);
    chk("done_row575", rd_q, frow(575, 16'h0));

    // restart after two and a half rows
    restart_r = 1'b1;
    tick();
    restart_r = 1'b0;
    sidx = 0;
    repeat (20) begin
      drive_beat(1'b1, 16'h8000);
      tick();
      if (last_acc) sidx += PAR;
    end
    drive_beat(1'b1, 16'h8000);
    restart_r = 1'b1;
    tick();
    restart_r = 1'b0;
    din_valid = 1'b0;
    tick();
    read1(11'd0);
    chk("partial_row0", rd_q, mm[0]);
    read1(11'd1);
    chk("partial_row1", rd_q, mm[1]);
    read1(11'd2);
    chk("partial_row2_old", rd_q, frow(2, 16'h0));

    // read row 5 in the same cycle it is written
    sidx = 0;
    repeat (5 * (T / PAR) + (T / PAR) - 1) begin
      drive_beat(1'b1, 16'h4000);
      tick();
      if (last_acc) sidx += PAR;
    end
    old5 = mm[5];
    drive_beat(1'b1, 16'h4000);
    rd_addr = 11'd5;
    rd_ce   = 1'b1;
    tick();
    if (last_acc) sidx += PAR;
    din_valid = 1'b0;
    tick();
    chk("rw_same_row_old", rd_q, old5);
    new5 = mm[5];
    tick();
    chk("rw_reread_new", rd_q, new5);
    chk("rw_new_content", rd_q, frow(5, 16'h4000));
    rd_ce   = 1'b0;
    rd_addr = '0;
    tick();
    tick();
    chk("rd_ce_hold", rd_q, new5);

    // randomized gaps and restarts must rebuild the full-load image
    restart_r = 1'b1;
    tick();
    restart_r = 1'b0;
    sidx  = 0;
    nrest = 0;
    cyc   = 0;
    while (!mdone && cyc < 40000) begin
      v  = ($urandom_range(0, 9) < 7);
      rs = (nrest < 3) && (sidx >= 64) && (sidx < 4000) && ($urandom_range(0, 99) == 0);
      drive_beat(v, 16'h0);
      restart_r = rs;
      tick();
      if (rs) begin
        sidx = 0;
        nrest++;
      end else if (last_acc) begin
        sidx += PAR;
      end
      cyc++;
    end
    restart_r = 1'b0;
    din_valid = 1'b0;
    chk("random_load_done", ROW_W'(load_done), ROW_W'(1));
    chk("random_load_elems", ROW_W'(sidx), ROW_W'(DEPTH * T));
    read_all_formula(16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
